// File: rtl/ddr_preload_engine.sv
// Copies NUM_WORDS 32-bit table words into DDR as DATA_W-bit Avalon-MM write beats.
// Optional read-back compare is enabled with `define DDR_PRELOAD_VERIFY_EN.
module ddr_preload_engine #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 25,
    parameter int NUM_WORDS = 28,
    parameter int BASE_ADDR = 0
) (
    input  logic                  avalon_clk,
    input  logic                  avalon_reset,
    input  logic                  start,
    input  logic                  cal_success,
    output logic [9:0]            tbl_addr,
    input  logic [31:0]           tbl_rdata,
    output logic [ADDR_W-1:0]     amm_address,
    output logic [DATA_W-1:0]     amm_writedata,
    output logic                  amm_write,
    output logic                  amm_read,
    output logic [DATA_W/8-1:0]   amm_byteenable,
    output logic [6:0]            amm_burstcount,
    input  logic                  amm_ready,
    input  logic [DATA_W-1:0]     amm_readdata,
    input  logic                  amm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           err_count
);

    localparam int WPB    = DATA_W / 32;
    localparam int NBEATS = (NUM_WORDS + WPB - 1) / WPB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_FETCH,
        S_WRITE,
`ifdef DDR_PRELOAD_VERIFY_EN
        S_VFETCH,
        S_VREAD,
        S_VWAIT,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [10:0]         beat;
    logic [4:0]          slot;
    logic [4:0]          cap_slot;
    logic                cap_valid;
    logic [DATA_W-1:0]   buf_q;
    logic [DATA_W-1:0]   beat_data;
    logic [DATA_W-1:0]   bit_mask;
    logic [DATA_W/8-1:0] be_mask;
    logic                last_beat;
    logic                fetch_last;
    logic                in_fetch;
    logic                in_req;

    assign last_beat  = (beat == 11'(NBEATS - 1));
    assign fetch_last = (slot == 5'(WPB - 1));

`ifdef DDR_PRELOAD_VERIFY_EN
    logic [15:0] err_cnt;
    assign in_fetch  = (state_q == S_FETCH) || (state_q == S_VFETCH);
    assign in_req    = (state_q == S_WRITE) || (state_q == S_VREAD);
    assign amm_read  = (state_q == S_VREAD);
    assign err_count = err_cnt;
`else
    logic unused_rd;
    assign unused_rd = ^{amm_readdata, amm_readdatavalid};
    assign in_fetch  = (state_q == S_FETCH);
    assign in_req    = (state_q == S_WRITE);
    assign amm_read  = 1'b0;
    assign err_count = '0;
`endif

    // The last table word lands in the first WRITE cycle, so it is forwarded
    // straight from tbl_rdata there and taken from buf_q afterwards.
    always_comb begin
        be_mask   = '0;
        bit_mask  = '0;
        beat_data = '0;
        for (int unsigned k = 0; k < WPB; k++) begin
            if (int'(beat) * WPB + int'(k) < NUM_WORDS) begin
                be_mask[k*4 +: 4]   = '1;
                bit_mask[k*32 +: 32] = '1;
            end
            beat_data[k*32 +: 32] = (cap_valid && cap_slot == 5'(k)) ? tbl_rdata : buf_q[k*32 +: 32];
        end
    end

    assign tbl_addr       = in_fetch ? 10'(int'(beat) * WPB + int'(slot)) : '0;
    assign amm_address    = in_req ? ADDR_W'(BASE_ADDR) + ADDR_W'(beat) : '0;
    assign amm_byteenable = in_req ? be_mask : '0;
    assign amm_write      = (state_q == S_WRITE);
    assign amm_writedata  = amm_write ? (beat_data & bit_mask) : '0;
    assign amm_burstcount = 7'd1;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WAIT_CAL;
            S_WAIT_CAL:     if (cal_success) state_d = S_FETCH;
            S_FETCH: begin
                if (!cal_success)    state_d = S_IDLE;
                else if (fetch_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (amm_ready) begin
                    if (!cal_success)   state_d = S_IDLE;
`ifdef DDR_PRELOAD_VERIFY_EN
                    else if (last_beat) state_d = S_VFETCH;
`else
                    else if (last_beat) state_d = S_DONE;
`endif
                    else                state_d = S_FETCH;
                end
            end
`ifdef DDR_PRELOAD_VERIFY_EN
            S_VFETCH: begin
                if (!cal_success)    state_d = S_IDLE;
                else if (fetch_last) state_d = S_VREAD;
            end
            S_VREAD: begin
                if (amm_ready) state_d = cal_success ? S_VWAIT : S_IDLE;
            end
            S_VWAIT: begin
                if (!cal_success)           state_d = S_IDLE;
                else if (amm_readdatavalid) state_d = last_beat ? S_DONE : S_VFETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            state_q   <= S_IDLE;
            beat      <= '0;
            slot      <= '0;
            cap_slot  <= '0;
            cap_valid <= 1'b0;
            buf_q     <= '0;
            error     <= 1'b0;
`ifdef DDR_PRELOAD_VERIFY_EN
            err_cnt   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cap_valid <= in_fetch;
            cap_slot  <= slot;
            if (cap_valid) buf_q[int'(cap_slot)*32 +: 32] <= tbl_rdata;
            if (in_fetch) slot <= fetch_last ? '0 : slot + 5'd1;
            // Only an abort path leads from a busy state back to IDLE.
            if (state_d == S_IDLE && state_q != S_IDLE) error <= 1'b1;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        beat  <= '0;
                        slot  <= '0;
                        error <= 1'b0;
`ifdef DDR_PRELOAD_VERIFY_EN
                        err_cnt <= '0;
`endif
                    end
                end
                S_WRITE: begin
                    if (amm_ready && cal_success) beat <= last_beat ? '0 : beat + 11'd1;
                end
`ifdef DDR_PRELOAD_VERIFY_EN
                S_VWAIT: begin
                    if (cal_success && amm_readdatavalid) begin
                        beat <= beat + 11'd1;
                        if (|((amm_readdata ^ buf_q) & bit_mask)) begin
                            error <= 1'b1;
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_preload_engine.sv
// Randomised self-checking bench for ddr_preload_engine with a table/slave model.
module tb_ddr_preload_engine;

    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 25;
    localparam int NUM_WORDS = 28;
    localparam int BASE_ADDR = 0;
    localparam int WPB       = DATA_W / 32;
    localparam int NBEATS    = (NUM_WORDS + WPB - 1) / WPB;
    localparam int TMO       = 3000;

    logic                  avalon_clk;
    logic                  avalon_reset;
    logic                  start;
    logic                  cal_success;
    logic [9:0]            tbl_addr;
    logic [31:0]           tbl_rdata;
    logic [ADDR_W-1:0]     amm_address;
    logic [DATA_W-1:0]     amm_writedata;
    logic                  amm_write;
    logic                  amm_read;
    logic [DATA_W/8-1:0]   amm_byteenable;
    logic [6:0]            amm_burstcount;
    logic                  amm_ready;
    logic [DATA_W-1:0]     amm_readdata;
    logic                  amm_readdatavalid;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [15:0]           err_count;

    ddr_preload_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset), .start(start),
        .cal_success(cal_success), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
        .amm_address(amm_address), .amm_writedata(amm_writedata), .amm_write(amm_write),
        .amm_read(amm_read), .amm_byteenable(amm_byteenable), .amm_burstcount(amm_burstcount),
        .amm_ready(amm_ready), .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
        .busy(busy), .done(done), .error(error), .err_count(err_count)
    );

    initial avalon_clk = 1'b0;
    always #5 avalon_clk = ~avalon_clk;

    logic [31:0]       tbl_mem [0:1023];
    logic [DATA_W-1:0] slave_mem [0:15];

    always @(posedge avalon_clk) tbl_rdata <= tbl_mem[tbl_addr];

    int n_chk, n_fail;
    int wr_n, rd_n, rd_total, stall_cnt, stall_left, mode;
    bit flip_b1, rd_pend;
    logic [ADDR_W-1:0]   rd_addr, first_addr;
    logic [DATA_W-1:0]   last_data, beat0_data;
    logic [DATA_W/8-1:0] last_be;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference beat: words b*WPB+k packed LSB-first, absent words zero.
    function automatic logic [DATA_W-1:0] exp_data(input int b);
        logic [DATA_W-1:0] r = '0;
        for (int k = 0; k < WPB; k++)
            if (b * WPB + k < NUM_WORDS) r[32*k +: 32] = tbl_mem[b * WPB + k];
        return r;
    endfunction

    function automatic logic [DATA_W/8-1:0] exp_be(input int b);
        logic [DATA_W/8-1:0] r = '0;
        for (int k = 0; k < WPB; k++)
            if (b * WPB + k < NUM_WORDS) r[4*k +: 4] = 4'hF;
        return r;
    endfunction

    // Monitor: samples on the falling edge, scores every handshake.
    initial begin
        logic                  pw;
        logic [ADDR_W-1:0]     pa;
        logic [DATA_W-1:0]     pd;
        logic [DATA_W/8-1:0]   pb;
        pw = 1'b0; pa = '0; pd = '0; pb = '0;
        forever begin
            @(negedge avalon_clk);
            if (amm_write || amm_read) chk("rw_exclusive", amm_write & amm_read, 0);
            if (pw) begin
                chk("hold_write", amm_write, 1);
                chk("hold_addr", amm_address, pa);
                chk("hold_data", amm_writedata, pd);
                chk("hold_be", amm_byteenable, pb);
            end
            pw = amm_write && !amm_ready;
            pa = amm_address; pd = amm_writedata; pb = amm_byteenable;
            if (amm_write && !amm_ready && amm_address == 1) stall_cnt++;
            if (amm_write && amm_ready) begin
                chk("write_in_range", wr_n < NBEATS, 1);
                if (wr_n < NBEATS) begin
                    chk("wr_addr", amm_address, ADDR_W'(BASE_ADDR + wr_n));
                    chk("wr_data", amm_writedata, exp_data(wr_n));
                    chk("wr_be", amm_byteenable, exp_be(wr_n));
                    chk("burstcount", amm_burstcount, 1);
                end
                if (wr_n == 0) begin
                    first_addr = amm_address;
                    beat0_data = amm_writedata;
                end
                last_data = amm_writedata;
                last_be   = amm_byteenable;
                slave_mem[amm_address[3:0]] = amm_writedata;
                wr_n++;
            end
            if (amm_read && amm_ready) begin
                rd_total++;
                chk("rd_addr", amm_address, ADDR_W'(BASE_ADDR + rd_n));
                chk("rd_be", amm_byteenable, exp_be(rd_n));
                rd_pend = 1'b1;
                rd_addr = amm_address;
                rd_n++;
            end
        end
    end

    // Slave driver: ready policy per mode, read data one cycle after accept.
    initial begin
        amm_ready = 1'b0; amm_readdatavalid = 1'b0; amm_readdata = '0;
        forever begin
            @(posedge avalon_clk);
            #1;
            case (mode)
                1: amm_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (amm_write && amm_address == 1 && stall_left > 0) begin
                        amm_ready = 1'b0;
                        stall_left--;
                    end else amm_ready = 1'b1;
                end
                4: amm_ready = !(amm_write && amm_address == 2);
                default: amm_ready = 1'b1;
            endcase
            if (rd_pend) begin
                amm_readdatavalid = 1'b1;
                amm_readdata = slave_mem[rd_addr[3:0]] ^ ((flip_b1 && rd_addr == 1) ? DATA_W'(1) : '0);
                rd_pend = 1'b0;
            end else begin
`ifdef DDR_PRELOAD_VERIFY_EN
                amm_readdatavalid = 1'b0;
`else
                amm_readdatavalid = ($urandom_range(0, 7) == 0);
                amm_readdata = {8{$urandom()}};
`endif
            end
        end
    end

    task automatic fill_table();
        for (int i = 0; i < 1024; i++) tbl_mem[i] = $urandom();
    endtask

    task automatic pulse_start();
        @(posedge avalon_clk); #1;
        wr_n = 0; rd_n = 0; start = 1'b1;
        @(posedge avalon_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < TMO) begin
            @(negedge avalon_clk);
            cycles++;
        end
        chk("done_timeout", cycles < TMO, 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < TMO) begin
            @(negedge avalon_clk);
            c++;
        end
        chk("idle_timeout", c < TMO, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tbl_addr"}, tbl_addr, 0);
        chk({tag, "_address"}, amm_address, 0);
        chk({tag, "_wdata"}, amm_writedata, 0);
        chk({tag, "_write"}, amm_write, 0);
        chk({tag, "_read"}, amm_read, 0);
        chk({tag, "_be"}, amm_byteenable, 0);
        chk({tag, "_burst"}, amm_burstcount, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_errcnt"}, err_count, 0);
    endtask

    initial begin
        int lat, c;
        n_chk = 0; n_fail = 0; wr_n = 0; rd_n = 0; rd_total = 0;
        stall_cnt = 0; stall_left = 0; mode = 0; flip_b1 = 1'b0; rd_pend = 1'b0;
        rd_addr = '0; first_addr = '1; last_data = '0; beat0_data = '0; last_be = '0;
        for (int i = 0; i < 16; i++) slave_mem[i] = '0;
        fill_table();
        tbl_mem[0] = 32'hDEADBEEF;
        avalon_reset = 1'b1; start = 1'b0; cal_success = 1'b1;
        repeat (3) @(negedge avalon_clk);
        check_zero_outputs("reset");
        @(posedge avalon_clk); #1;
        avalon_reset = 1'b0;

        // Baseline: ready always high.
        pulse_start();
        wait_done(lat);
        chk("a_writes", wr_n, NBEATS);
        chk("a_done", done, 1);
        chk("a_error", error, 0);
        chk("a_errcnt", err_count, 0);
        chk("a_busy", busy, 0);
        chk("a_last_be", last_be, 32'h0000FFFF);
        chk("a_last_upper_zero", last_data[255:128], 0);
        chk("a_beat0_word0", beat0_data[31:0], 32'hDEADBEEF);
        chk("a_beat0_word1", beat0_data[63:32], tbl_mem[1]);
`ifdef DDR_PRELOAD_VERIFY_EN
        chk("a_reads", rd_n, NBEATS);
`else
        chk("a_latency", (lat >= NBEATS * (WPB + 1)) && (lat <= NBEATS * (WPB + 1) + 3), 1);
`endif

        // Random table contents with random ready back-pressure.
        mode = 1;
        for (int r = 0; r < 4; r++) begin
            fill_table();
            pulse_start();
            wait_done(lat);
            chk("b_writes", wr_n, NBEATS);
            chk("b_error", error, 0);
        end

        // Five-cycle stall on beat 1.
        mode = 2; stall_left = 5; stall_cnt = 0;
        pulse_start();
        wait_done(lat);
        chk("c_stall_cycles", stall_cnt, 5);
        chk("c_writes", wr_n, NBEATS);

        // Calibration arrives 20 cycles after start.
        mode = 1; cal_success = 1'b0;
        pulse_start();
        repeat (20) begin
            @(negedge avalon_clk);
            chk("d_busy", busy, 1);
            chk("d_tbl_addr", tbl_addr, 0);
            chk("d_write", amm_write, 0);
        end
        @(posedge avalon_clk); #1;
        cal_success = 1'b1;
        wait_done(lat);
        chk("d_writes", wr_n, NBEATS);
        chk("d_error", error, 0);

        // Calibration lost while beat 2 is held off.
        mode = 4;
        pulse_start();
        c = 0;
        while (!(amm_write && amm_address == 2) && c < TMO) begin
            @(negedge avalon_clk);
            c++;
        end
        chk("e_reach_beat2", c < TMO, 1);
        @(posedge avalon_clk); #1;
        cal_success = 1'b0;
        repeat (3) @(negedge avalon_clk);
        mode = 0;
        wait_idle();
        chk("e_writes", wr_n, 3);
        chk("e_error", error, 1);
        chk("e_done", done, 0);
        chk("e_busy", busy, 0);
        repeat (10) @(negedge avalon_clk);
        chk("e_no_beat3", wr_n, 3);
        cal_success = 1'b1;

        // A second start while busy must be ignored.
        pulse_start();
        repeat (5) @(negedge avalon_clk);
        @(posedge avalon_clk); #1;
        start = 1'b1;
        @(posedge avalon_clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("f_writes", wr_n, NBEATS);
        chk("f_error", error, 0);

        // Reset during the fetch of beat 1, then restart.
        pulse_start();
        c = 0;
        while (wr_n < 1 && c < TMO) begin
            @(negedge avalon_clk);
            c++;
        end
        chk("g_reach_beat1", c < TMO, 1);
        repeat (2) @(negedge avalon_clk);
        @(posedge avalon_clk); #1;
        avalon_reset = 1'b1;
        @(negedge avalon_clk);
        check_zero_outputs("g_reset");
        @(posedge avalon_clk); #1;
        avalon_reset = 1'b0;
        repeat (5) begin
            @(negedge avalon_clk);
            chk("g_quiet_write", amm_write, 0);
            chk("g_quiet_busy", busy, 0);
        end
        first_addr = '1;
        pulse_start();
        wait_done(lat);
        chk("g_first_addr", first_addr, 0);
        chk("g_writes", wr_n, NBEATS);

`ifdef DDR_PRELOAD_VERIFY_EN
        // Corrupted read-back on beat 1.
        flip_b1 = 1'b1;
        pulse_start();
        wait_done(lat);
        chk("h_errcnt", err_count, 1);
        chk("h_error", error, 1);
        chk("h_done", done, 1);
        flip_b1 = 1'b0;
`else
        chk("no_reads", rd_total, 0);
`endif

        repeat (3) @(negedge avalon_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
